// File: rtl/wallace_div_pkg.sv
// Shared widths, state encoding and constants for the restoring divider.
// Purely declarative; no logic, latency or backpressure of its own.
package wallace_div_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int CNT_W      = 4;

  localparam logic [DIVIDEND_W-1:0] DBZ_QUOTIENT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

endpackage

// File: rtl/restoring_div_step.sv
// One radix-2 restoring step: compare trial against divisor, subtract if it fits.
// Combinational, zero latency; no handshake.
module restoring_div_step
  import wallace_div_pkg::*;
(
  input  logic [DIVISOR_W:0]   trial,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] rem_nxt,
  output logic                 q_bit
);

  always_comb begin
    q_bit = (trial >= {1'b0, divisor});
    // The result is always below the divisor, so 8-bit modular subtraction is exact.
    rem_nxt = q_bit ? (trial[DIVISOR_W-1:0] - divisor) : trial[DIVISOR_W-1:0];
  end

endmodule

// File: rtl/wallace_product_restoring_divider.sv
// Unsigned 16/8 restoring divider, one quotient bit per cycle; DIVIDER_FAST_BYPASS_EN adds fast paths.
// Latency: 16 edges after accept; divide-by-zero (and bypass cases) complete on the accept edge.
// Backpressure: result is held in DONE until out_ready; no new operand accepted until back in IDLE.
module wallace_product_restoring_divider
  import wallace_div_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  state_t                  state_q, state_d;
  logic [DIVISOR_W-1:0]    div_q, div_d;
  logic [DIVISOR_W-1:0]    rem_q, rem_d;
  logic [DIVIDEND_W-1:0]   quot_q, quot_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    dbz_q, dbz_d;

  logic [DIVISOR_W:0]      trial;
  logic [DIVISOR_W-1:0]    step_rem;
  logic                    step_q;

  // The quotient register doubles as the dividend shift register.
  assign trial = {rem_q, quot_q[DIVIDEND_W-1]};

  restoring_div_step u_step (
    .trial   (trial),
    .divisor (div_q),
    .rem_nxt (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          div_d  = divisor;
          rem_d  = '0;
          quot_d = dividend;
          cnt_d  = '0;
          if (divisor == '0) begin
            state_d = DONE;
            quot_d  = DBZ_QUOTIENT;
            rem_d   = dividend[DIVISOR_W-1:0];
            dbz_d   = 1'b1;
          end
`ifdef DIVIDER_FAST_BYPASS_EN
          else if (dividend == '0 || divisor == DIVISOR_W'(1)) begin
            state_d = DONE;
            dbz_d   = 1'b0;
          end
`endif
          else begin
            state_d = BUSY;
            dbz_d   = 1'b0;
          end
        end
      end
      BUSY: begin
        rem_d  = step_rem;
        quot_d = {quot_q[DIVIDEND_W-2:0], step_q};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
